// File: rtl/prog_memory_pkg.sv
// Shared types and constants for the program memory and its loader.
// The IMEM_BOOT_EN build reloads the low words from BOOT_IMAGE on reset.
package prog_memory_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OP_W = 16;

    localparam logic [OP_W-1:0] NOP  = 16'h0000;
    localparam logic [OP_W-1:0] HALT = 16'hFFFF;

    localparam int BOOT_LEN = 4;

    localparam logic [OP_W-1:0] BOOT_IMAGE [BOOT_LEN] = '{
        16'h1001,
        16'h2002,
        NOP,
        HALT
    };

    function automatic int idx_width(input int data_w);
        int bytes;
        bytes = data_w / 8;
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/prog_memory_ld_word_asm.sv
// Assembles a stream of load bytes into one instruction word, low byte first.
// The complete flag marks the cycle in which the final byte is taken.
module ld_word_asm
    import prog_memory_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              complete
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = idx_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0]   idx;
    logic [DATA_W+7:0]  shifted;

    // New bytes enter at the top, so the first byte ends up lowest.
    assign shifted  = {byte_in, word};
    assign complete = byte_en && (idx == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (byte_en) begin
            word <= shifted[DATA_W+7:8];
            idx  <= complete ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/prog_memory.sv
// Instruction RAM with a byte-serial program loader and a 1-cycle fetch port.
// Define IMEM_BOOT_EN to preload BOOT_IMAGE into the low words on reset.
module prog_memory
    import prog_memory_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_count,
    input  logic              ld_abort,
    input  logic [7:0]        ld_byte,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   word;
    logic                complete;
    logic                byte_en;
    logic                asm_clear;
    logic                we;
    logic                aborting;

    assign aborting  = ld_abort && (state != IDLE);
    assign byte_en   = (state == RECV) && ld_ready && ld_valid && !ld_abort;
    assign asm_clear = (state == IDLE) || ld_abort;
    assign we        = (state == WRITE) && !ld_abort;

    ld_word_asm #(
        .DATA_W(DATA_W)
    ) u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (asm_clear),
        .byte_en  (byte_en),
        .byte_in  (ld_byte),
        .word     (word),
        .complete (complete)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            ld_ready  <= 1'b0;
            ld_busy   <= 1'b0;
            ld_done   <= 1'b0;
            ld_err    <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
            if (aborting) begin
                state    <= IDLE;
                ld_ready <= 1'b0;
                ld_busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ld_start && ld_count != '0) begin
                            addr      <= ld_base;
                            remaining <= ld_count;
                            state     <= RECV;
                            ld_ready  <= 1'b1;
                            ld_busy   <= 1'b1;
                        end else if (ld_start) begin
                            ld_err <= 1'b1;
                        end
                    end
                    RECV: begin
                        if (complete) begin
                            state    <= WRITE;
                            ld_ready <= 1'b0;
                        end
                    end
                    WRITE: begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_W+1)'(1)) begin
                            state   <= DONE;
                            ld_done <= 1'b1;
                        end else begin
                            state    <= RECV;
                            ld_ready <= 1'b1;
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        ld_busy <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        ld_ready <= 1'b0;
                        ld_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef IMEM_BOOT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BOOT_LEN; i++) begin
                mem[i] <= DATA_W'(BOOT_IMAGE[i]);
            end
        end else if (we) begin
            mem[addr] <= word;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= word;
        end
    end
`endif

    // Reads sample the RAM before any write of the same edge lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
        end else if (fetch_en && state == IDLE) begin
            fetch_valid <= 1'b1;
            fetch_data  <= mem[fetch_addr];
        end else begin
            fetch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_memory.sv
// Directed bench for prog_memory: loads, wrap, abort, zero count, reset.
// Fetch results are checked against a word model through a scoreboard queue.
module tb_prog_memory;
    import prog_memory_pkg::*;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [7:0]  fetch_addr;
    logic [15:0] fetch_data;
    logic        fetch_valid;
    logic        ld_start;
    logic [7:0]  ld_base;
    logic [8:0]  ld_count;
    logic        ld_abort;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [256];
    logic [15:0] sb [$];
    logic [15:0] wq [$];
    logic        watch;
    logic [15:0] held;

    prog_memory #(
        .DATA_W(16),
        .ADDR_W(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_count    (ld_count),
        .ld_abort    (ld_abort),
        .ld_byte     (ld_byte),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done),
        .ld_err      (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_chk();
        if (watch) begin
            chk("hold_valid", 32'(fetch_valid), 32'd0);
            chk("hold_data", 32'(fetch_data), 32'(held));
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_byte  = b;
        while (!ld_ready && n < 20) begin
            step();
            hold_chk();
            n++;
        end
        chk("ready_seen", 32'(ld_ready), 32'd1);
        step();
        hold_chk();
        ld_valid = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] base, input int n);
        ld_start = 1'b1;
        ld_base  = base;
        ld_count = 9'(n);
        step();
        ld_start = 1'b0;
        chk("busy_start", 32'(ld_busy), 32'd1);
        for (int w = 0; w < n; w++) begin
            send(wq[w][7:0]);
            send(wq[w][15:8]);
            model[8'(32'(base) + w)] = wq[w];
        end
        chk("done_early", 32'(ld_done), 32'd0);
        step();
        chk("done_pulse", 32'(ld_done), 32'd1);
        step();
        chk("done_clear", 32'(ld_done), 32'd0);
        chk("busy_end", 32'(ld_busy), 32'd0);
    endtask

    task automatic fetch(input logic [7:0] a);
        fetch_en   = 1'b1;
        fetch_addr = a;
        sb.push_back(model[a]);
        step();
        fetch_en = 1'b0;
        chk("fetch_valid", 32'(fetch_valid), 32'd1);
        chk("fetch_data", 32'(fetch_data), 32'(sb.pop_front()));
    endtask

    task automatic boot_model();
`ifdef IMEM_BOOT_EN
        for (int i = 0; i < BOOT_LEN; i++) model[i] = BOOT_IMAGE[i];
`endif
    endtask

    initial begin
        rst        = 1'b0;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        ld_start   = 1'b0;
        ld_base    = '0;
        ld_count   = '0;
        ld_abort   = 1'b0;
        ld_byte    = '0;
        ld_valid   = 1'b0;
        watch      = 1'b0;
        held       = '0;
        boot_model();

        step();
        step();
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_busy", 32'(ld_busy), 32'd0);
        chk("rst_done", 32'(ld_done), 32'd0);
        chk("rst_err", 32'(ld_err), 32'd0);
        chk("rst_fvalid", 32'(fetch_valid), 32'd0);
        chk("rst_fdata", 32'(fetch_data), 32'd0);
        rst = 1'b1;
        step();

        // zero-length start
        ld_start = 1'b1;
        ld_count = 9'd0;
        ld_base  = 8'h20;
        step();
        ld_start = 1'b0;
        chk("zero_err", 32'(ld_err), 32'd1);
        chk("zero_busy", 32'(ld_busy), 32'd0);
        step();
        chk("zero_err_clr", 32'(ld_err), 32'd0);
        chk("zero_busy2", 32'(ld_busy), 32'd0);

        // two-word load at 0x10
        wq = '{16'h1234, 16'h5678};
        do_load(8'h10, 2);
        fetch(8'h11);
        step();
        chk("fvalid_drop", 32'(fetch_valid), 32'd0);
        chk("fdata_keep", 32'(fetch_data), 32'h5678);
        fetch(8'h10);

        // wrap from 0xFF to 0x00
        wq = '{16'hAAAA, 16'hBBBB};
        do_load(8'hFF, 2);
        fetch(8'hFF);
        fetch(8'h00);

        // abort during second word
        wq = '{16'hCAFE};
        do_load(8'h41, 1);
        ld_start = 1'b1;
        ld_base  = 8'h40;
        ld_count = 9'd2;
        step();
        ld_start = 1'b0;
        send(8'h11);
        send(8'h22);
        model[8'h40] = 16'h2211;
        send(8'h33);
        chk("pre_abort_ready", 32'(ld_ready), 32'd1);
        ld_abort = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'h44;
        step();
        ld_abort = 1'b0;
        ld_valid = 1'b0;
        chk("abort_busy", 32'(ld_busy), 32'd0);
        chk("abort_ready", 32'(ld_ready), 32'd0);
        chk("abort_done", 32'(ld_done), 32'd0);
        step();
        chk("abort_done2", 32'(ld_done), 32'd0);
        step();
        chk("abort_done3", 32'(ld_done), 32'd0);
        fetch(8'h40);
        fetch(8'h41);
        wq = '{16'hBEEF};
        do_load(8'h42, 1);
        fetch(8'h42);

        // fetch same cycle as start, then fetch held off while busy
        wq = '{16'h5050};
        do_load(8'h50, 1);
        fetch_en   = 1'b1;
        fetch_addr = 8'h50;
        sb.push_back(model[8'h50]);
        ld_start   = 1'b1;
        ld_base    = 8'h50;
        ld_count   = 9'd1;
        step();
        ld_start = 1'b0;
        chk("pre_load_valid", 32'(fetch_valid), 32'd1);
        chk("pre_load_data", 32'(fetch_data), 32'(sb.pop_front()));
        held  = 16'h5050;
        watch = 1'b1;
        ld_start = 1'b1;
        ld_count = 9'd0;
        send(8'h05);
        ld_start = 1'b0;
        chk("busy_start_ignored", 32'(ld_err), 32'd0);
        send(8'h05);
        model[8'h50] = 16'h0505;
        step();
        hold_chk();
        chk("fl_done", 32'(ld_done), 32'd1);
        step();
        hold_chk();
        watch = 1'b0;
        chk("fl_busy_end", 32'(ld_busy), 32'd0);
        fetch(8'h50);

        // reset in the middle of RECV
        ld_start = 1'b1;
        ld_base  = 8'h60;
        ld_count = 9'd2;
        step();
        ld_start = 1'b0;
        send(8'h99);
        fetch_en   = 1'b1;
        fetch_addr = 8'h10;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ld_ready), 32'd0);
        chk("mid_rst_busy", 32'(ld_busy), 32'd0);
        chk("mid_rst_done", 32'(ld_done), 32'd0);
        chk("mid_rst_err", 32'(ld_err), 32'd0);
        chk("mid_rst_fvalid", 32'(fetch_valid), 32'd0);
        chk("mid_rst_fdata", 32'(fetch_data), 32'd0);
        fetch_en = 1'b0;
        boot_model();
        step();
        rst = 1'b1;
        step();
        chk("post_rst_done", 32'(ld_done), 32'd0);
        chk("post_rst_busy", 32'(ld_busy), 32'd0);
        fetch(8'h00);
        fetch(8'h10);
        fetch(8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
